// File: rtl/conv_stream_gen.sv
// Streaming 1-D valid-mode convolution: persistent filter, pipelined MAC,
// output FIFO with issue gating, optional ReLU on the result path.
module conv_stream_gen #(
  parameter int WIDTH     = 10,
  parameter int OUT_WIDTH = 26,
  parameter int SIZE_X    = 112,
  parameter int SIZE_F    = 49,
  parameter int MAC_PIPE  = 2,
  parameter int OUT_DEPTH = 4,
  parameter int RELU      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     x_data,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic signed [WIDTH-1:0]     f_data,
  input  logic                        f_valid,
  output logic                        f_ready,
  output logic signed [OUT_WIDTH-1:0] y_data,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  // Handshake: a word moves on a cycle where valid && ready; ready is decoded
  // from state (plus f_valid for x in IDLE, so the filter wins a tie).
  localparam int NOUT = SIZE_X - SIZE_F + 1;
  localparam int XA_W = $clog2(SIZE_X);
  localparam int FA_W = $clog2(SIZE_F);
  localparam int PW   = $clog2(OUT_DEPTH);
  localparam int CW   = $clog2(OUT_DEPTH + 1);
  localparam logic [XA_W-1:0] X_LAST = XA_W'(SIZE_X - 1);
  localparam logic [XA_W-1:0] K_LAST = XA_W'(NOUT - 1);
  localparam logic [FA_W-1:0] F_LAST = FA_W'(SIZE_F - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_F, S_LOAD_X, S_COMPUTE} state_t;

  state_t                    r_state;
  logic                      r_filter_loaded;
  logic [FA_W-1:0]           r_fcnt, r_j;
  logic [XA_W-1:0]           r_xcnt, r_k;
  logic                      r_issue_done;
  logic [CW-1:0]             r_inflight, r_cnt;
  logic signed [WIDTH-1:0]   r_xmem [SIZE_X];
  logic signed [WIDTH-1:0]   r_fmem [SIZE_F];
  logic                      r_iv, r_if, r_il, r_rv, r_rf, r_rl;
  logic [XA_W-1:0]           r_ixa;
  logic [FA_W-1:0]           r_ifa;
  logic signed [WIDTH-1:0]   r_rx, r_rfd;
  logic [MAC_PIPE-1:0]       r_pv, r_pf, r_pl;
  logic signed [OUT_WIDTH-1:0] r_p [MAC_PIPE];
  logic signed [OUT_WIDTH-1:0] r_acc;
  logic signed [OUT_WIDTH-1:0] r_fifo [OUT_DEPTH];
  logic [PW-1:0]             r_wp, r_rp;

  logic                        w_f_hs, w_x_hs, w_room, w_issue, w_inc, w_wr, w_pop;
  logic signed [2*WIDTH-1:0]   w_mul;
  logic signed [OUT_WIDTH-1:0] w_prod, w_sum, w_wdata;

  assign f_ready   = reset && (r_state == S_IDLE || r_state == S_LOAD_F);
  assign x_ready   = (r_state == S_IDLE && r_filter_loaded && !f_valid) || r_state == S_LOAD_X;
  assign w_f_hs    = f_valid && f_ready;
  assign w_x_hs    = x_valid && x_ready;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  // A new output may start only when its result is guaranteed a FIFO slot.
  assign w_room  = ({1'b0, r_cnt} + {1'b0, r_inflight}) < (CW+1)'(OUT_DEPTH);
  assign w_issue = (r_state == S_COMPUTE) && !r_issue_done && (r_j != '0 || w_room);
  assign w_inc   = w_issue && (r_j == '0);

  assign w_mul   = (2*WIDTH)'(r_rx) * (2*WIDTH)'(r_rfd);
  assign w_prod  = OUT_WIDTH'(w_mul);
  assign w_sum   = r_pf[MAC_PIPE-1] ? r_p[MAC_PIPE-1] : r_acc + r_p[MAC_PIPE-1];
  assign w_wr    = r_pv[MAC_PIPE-1] && r_pl[MAC_PIPE-1];
  assign w_wdata = (RELU != 0 && w_sum[OUT_WIDTH-1]) ? '0 : w_sum;

  assign y_valid = (r_cnt != '0);
  assign y_data  = y_valid ? r_fifo[r_rp] : '0;
  assign w_pop   = y_valid && y_ready;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_filter_loaded <= 1'b0;
      r_fcnt          <= '0;
      r_xcnt          <= '0;
      r_k             <= '0;
      r_j             <= '0;
      r_issue_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_f_hs) begin
            r_fcnt  <= FA_W'(1);
            r_state <= S_LOAD_F;
          end else if (w_x_hs) begin
            r_xcnt  <= XA_W'(1);
            r_state <= S_LOAD_X;
          end
        end
        S_LOAD_F: begin
          if (w_f_hs) begin
            if (r_fcnt == F_LAST) begin
              r_fcnt          <= '0;
              r_filter_loaded <= 1'b1;
              r_state         <= S_IDLE;
            end else begin
              r_fcnt <= r_fcnt + FA_W'(1);
            end
          end
        end
        S_LOAD_X: begin
          if (w_x_hs) begin
            if (r_xcnt == X_LAST) begin
              r_xcnt       <= '0;
              r_k          <= '0;
              r_j          <= '0;
              r_issue_done <= 1'b0;
              r_state      <= S_COMPUTE;
            end else begin
              r_xcnt <= r_xcnt + XA_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (w_issue) begin
            if (r_j == F_LAST) begin
              r_j <= '0;
              if (r_k == K_LAST) r_issue_done <= 1'b1;
              else               r_k <= r_k + XA_W'(1);
            end else begin
              r_j <= r_j + FA_W'(1);
            end
          end
          if (r_issue_done && r_inflight == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_x_hs) r_xmem[r_xcnt] <= x_data;
    if (w_f_hs) r_fmem[r_fcnt] <= f_data;
    r_rx  <= r_xmem[r_ixa];
    r_rfd <= r_fmem[r_ifa];
    if (w_wr) r_fifo[r_wp] <= w_wdata;
  end

  // Issue register -> memory read register -> MAC_PIPE product stages -> accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iv       <= 1'b0;
      r_if       <= 1'b0;
      r_il       <= 1'b0;
      r_ixa      <= '0;
      r_ifa      <= '0;
      r_rv       <= 1'b0;
      r_rf       <= 1'b0;
      r_rl       <= 1'b0;
      r_pv       <= '0;
      r_pf       <= '0;
      r_pl       <= '0;
      for (int i = 0; i < MAC_PIPE; i++) r_p[i] <= '0;
      r_acc      <= '0;
      r_inflight <= '0;
    end else begin
      r_iv  <= w_issue;
      r_ixa <= r_k + XA_W'(r_j);
      r_ifa <= r_j;
      r_if  <= (r_j == '0);
      r_il  <= (r_j == F_LAST);
      r_rv  <= r_iv;
      r_rf  <= r_if;
      r_rl  <= r_il;
      r_pv[0] <= r_rv;
      r_pf[0] <= r_rf;
      r_pl[0] <= r_rl;
      r_p[0]  <= w_prod;
      for (int i = 1; i < MAC_PIPE; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
        r_p[i]  <= r_p[i-1];
      end
      if (r_pv[MAC_PIPE-1]) r_acc <= w_sum;
      if (w_inc && !w_wr)      r_inflight <= r_inflight + CW'(1);
      else if (!w_inc && w_wr) r_inflight <= r_inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= f_next(r_wp);
      if (w_pop) r_rp <= f_next(r_rp);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_conv_stream_gen.sv
// Bench for conv_stream_gen: three parameterisations driven by directed and
// random vectors, results checked against a sum-of-products reference model.
module tb_conv_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [3];
  logic [9:0] x_data  [3];
  logic [9:0] f_data  [3];
  logic       x_valid [3];
  logic       f_valid [3];
  logic       y_ready [3];
  logic       x_ready [3];
  logic       f_ready [3];
  logic       y_valid [3];
  logic       busy    [3];
  logic [1:0] dbg     [3];
  logic [25:0] y_data0, y_data1;
  logic [19:0] y_data2;
  logic [31:0] y32 [3];

  assign y32[0] = {6'd0, y_data0};
  assign y32[1] = {6'd0, y_data1};
  assign y32[2] = {12'd0, y_data2};

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  int          cur_d = 0;
  bit          rnd_ready = 0;
  int          stall_max = 0;
  int          x_cur[$];
  int          f_cur[$];

  conv_stream_gen #(.WIDTH(10), .OUT_WIDTH(26), .SIZE_X(8), .SIZE_F(3), .MAC_PIPE(2),
                    .OUT_DEPTH(4), .RELU(0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .x_data(x_data[0]), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
    .f_data(f_data[0]), .f_valid(f_valid[0]), .f_ready(f_ready[0]), .y_data(y_data0),
    .y_valid(y_valid[0]), .y_ready(y_ready[0]), .busy(busy[0]), .dbg_state(dbg[0]));

  conv_stream_gen #(.WIDTH(10), .OUT_WIDTH(26), .SIZE_X(8), .SIZE_F(3), .MAC_PIPE(2),
                    .OUT_DEPTH(4), .RELU(1)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .x_data(x_data[1]), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
    .f_data(f_data[1]), .f_valid(f_valid[1]), .f_ready(f_ready[1]), .y_data(y_data1),
    .y_valid(y_valid[1]), .y_ready(y_ready[1]), .busy(busy[1]), .dbg_state(dbg[1]));

  conv_stream_gen #(.WIDTH(10), .OUT_WIDTH(20), .SIZE_X(52), .SIZE_F(49), .MAC_PIPE(2),
                    .OUT_DEPTH(4), .RELU(0)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .x_data(x_data[2]), .x_valid(x_valid[2]), .x_ready(x_ready[2]),
    .f_data(f_data[2]), .f_valid(f_valid[2]), .f_ready(f_ready[2]), .y_data(y_data2),
    .y_valid(y_valid[2]), .y_ready(y_ready[2]), .busy(busy[2]), .dbg_state(dbg[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) y_ready[cur_d] = 1'($urandom_range(0, 1));
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic send(input int d, input bit is_f, input int val);
    int n;
    bit done;
    n = 0;
    done = 0;
    repeat ($urandom_range(0, stall_max)) tick();
    if (is_f) begin f_valid[d] = 1'b1; f_data[d] = 10'(val); end
    else      begin x_valid[d] = 1'b1; x_data[d] = 10'(val); end
    while (!done && n < 300) begin
      @(negedge clk);
      done = is_f ? f_ready[d] : x_ready[d];
      tick();
      n++;
    end
    if (is_f) f_valid[d] = 1'b0;
    else      x_valid[d] = 1'b0;
    check(is_f ? "f_handshake" : "x_handshake", {63'd0, done}, 64'd1);
  endtask

  task automatic load_f(input int d);
    foreach (f_cur[i]) send(d, 1'b1, f_cur[i]);
  endtask

  task automatic load_x(input int d);
    foreach (x_cur[i]) send(d, 1'b0, x_cur[i]);
  endtask

  // Reference: plain sum of products, reduced modulo 2^ow once at the end.
  task automatic model(input int ow, input bit relu);
    longint s;
    for (int k = 0; k <= x_cur.size() - f_cur.size(); k++) begin
      s = 0;
      for (int j = 0; j < f_cur.size(); j++) s += longint'(x_cur[k+j]) * longint'(f_cur[j]);
      s = s & ((longint'(1) << ow) - 1);
      if (relu && s[ow-1]) s = 0;
      exp_q.push_back(32'(s));
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy[d]) && n < 3000) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("busy_after", {63'd0, busy[d]}, 64'd0);
    check("y_valid_after", {63'd0, y_valid[d]}, 64'd0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (y_valid[d] === 1'b1 && y_ready[d] === 1'b1) begin
        if (d == cur_d && exp_q.size() != 0) check("y_data", {32'd0, y32[d]}, {32'd0, exp_q.pop_front()});
        else check("y_unexpected_pop", {63'd0, y_valid[d]}, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; x_data[d] = '0; f_data[d] = '0;
      x_valid[d] = 1'b0; f_valid[d] = 1'b0; y_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_x_ready", {63'd0, x_ready[d]}, 64'd0);
      check("rst_f_ready", {63'd0, f_ready[d]}, 64'd0);
      check("rst_y_valid", {63'd0, y_valid[d]}, 64'd0);
      check("rst_y_data", {32'd0, y32[d]}, 64'd0);
      check("rst_busy", {63'd0, busy[d]}, 64'd0);
      rst_n[d] = 1'b1;
    end
    tick();
    x_valid[0] = 1'b1; x_data[0] = 10'd3;
    @(negedge clk);
    check("no_filter_x_ready", {63'd0, x_ready[0]}, 64'd0);
    check("idle_f_ready", {63'd0, f_ready[0]}, 64'd1);
    tick();
    x_valid[0] = 1'b0;

    // Basic vector, latency from last x handshake to first y_valid.
    cur_d = 0; y_ready[0] = 1'b1; stall_max = 0;
    f_cur = '{1, 1, 1};
    load_f(0);
    x_cur = '{1, 2, 3, 4, 5, 6, 7, 8};
    model(26, 1'b0);
    load_x(0);
    n = 0;
    @(negedge clk);
    while (!y_valid[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("first_y_latency", 64'(n), 64'd7);
    wait_drain(0);

    // Consumer stalled for 100 cycles: FIFO full, compute held.
    y_ready[0] = 1'b0;
    model(26, 1'b0);
    load_x(0);
    repeat (100) tick();
    @(negedge clk);
    check("stall_y_valid", {63'd0, y_valid[0]}, 64'd1);
    check("stall_y_head", {32'd0, y32[0]}, {32'd0, exp_q[0]});
    check("stall_busy", {63'd0, busy[0]}, 64'd1);
    check("stall_state_compute", {62'd0, dbg[0]}, 64'd3);
    tick();
    y_ready[0] = 1'b1;
    wait_drain(0);

    // Filter reuse.
    x_cur = '{2, 0, 0, 0, 0, 0, 0, 1};
    model(26, 1'b0);
    load_x(0);
    wait_drain(0);

    // Random vectors with stalls, random consumer, occasional filter reload.
    for (int r = 0; r < 5; r++) begin
      stall_max = r % 3;
      rnd_ready = 1;
      if (r == 0 || $urandom_range(0, 1) == 1) begin
        f_cur.delete();
        for (int j = 0; j < 3; j++) f_cur.push_back(rnd_s());
        load_f(0);
      end
      x_cur.delete();
      for (int i = 0; i < 8; i++) x_cur.push_back(rnd_s());
      model(26, 1'b0);
      load_x(0);
    end
    rnd_ready = 0; y_ready[0] = 1'b1; stall_max = 0;
    wait_drain(0);

    // ReLU instance: filter beats x on a shared IDLE cycle.
    cur_d = 1; y_ready[1] = 1'b1;
    f_cur = '{1, 1, 1};
    load_f(1);
    f_valid[1] = 1'b1; f_data[1] = 10'h3FF; x_valid[1] = 1'b1; x_data[1] = 10'd1;
    @(negedge clk);
    check("tie_x_ready", {63'd0, x_ready[1]}, 64'd0);
    check("tie_f_ready", {63'd0, f_ready[1]}, 64'd1);
    tick();
    f_valid[1] = 1'b0;
    @(negedge clk);
    check("tie_state_load_f", {62'd0, dbg[1]}, 64'd1);
    check("load_f_x_ready", {63'd0, x_ready[1]}, 64'd0);
    tick();
    send(1, 1'b1, 0);
    send(1, 1'b1, 0);
    x_valid[1] = 1'b0;
    f_cur = '{-1, 0, 0};
    x_cur = '{1, 2, 3, 4, 5, 6, 7, 8};
    model(26, 1'b1);
    load_x(1);
    wait_drain(1);
    for (int r = 0; r < 2; r++) begin
      f_cur.delete();
      x_cur.delete();
      for (int j = 0; j < 3; j++) f_cur.push_back(rnd_s());
      for (int i = 0; i < 8; i++) x_cur.push_back(rnd_s());
      load_f(1);
      model(26, 1'b1);
      load_x(1);
      wait_drain(1);
    end

    // Long filter with 20-bit wrapping accumulator.
    cur_d = 2; y_ready[2] = 1'b1;
    f_cur.delete();
    x_cur.delete();
    for (int j = 0; j < 49; j++) f_cur.push_back(-512);
    for (int i = 0; i < 52; i++) x_cur.push_back(-512);
    load_f(2);
    model(20, 1'b0);
    load_x(2);
    wait_drain(2);
    f_cur.delete();
    x_cur.delete();
    for (int j = 0; j < 49; j++) f_cur.push_back(rnd_s());
    for (int i = 0; i < 52; i++) x_cur.push_back(rnd_s());
    load_f(2);
    model(20, 1'b0);
    load_x(2);
    wait_drain(2);

    // Asynchronous reset while computing.
    cur_d = 0; y_ready[0] = 1'b0;
    x_cur.delete();
    for (int i = 0; i < 8; i++) x_cur.push_back(rnd_s());
    load_x(0);
    repeat (30) tick();
    @(negedge clk);
    check("pre_rst_y_valid", {63'd0, y_valid[0]}, 64'd1);
    check("pre_rst_busy", {63'd0, busy[0]}, 64'd1);
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_x_ready", {63'd0, x_ready[0]}, 64'd0);
    check("mid_rst_f_ready", {63'd0, f_ready[0]}, 64'd0);
    check("mid_rst_y_valid", {63'd0, y_valid[0]}, 64'd0);
    check("mid_rst_y_data", {32'd0, y32[0]}, 64'd0);
    check("mid_rst_busy", {63'd0, busy[0]}, 64'd0);
    tick();
    rst_n[0] = 1'b1;
    tick();
    x_valid[0] = 1'b1; x_data[0] = 10'd5;
    @(negedge clk);
    check("post_rst_x_ready", {63'd0, x_ready[0]}, 64'd0);
    check("post_rst_f_ready", {63'd0, f_ready[0]}, 64'd1);
    check("post_rst_y_valid", {63'd0, y_valid[0]}, 64'd0);
    tick();
    x_valid[0] = 1'b0;
    y_ready[0] = 1'b1;
    f_cur.delete();
    x_cur.delete();
    for (int j = 0; j < 3; j++) f_cur.push_back(rnd_s());
    for (int i = 0; i < 8; i++) x_cur.push_back(rnd_s());
    load_f(0);
    model(26, 1'b0);
    load_x(0);
    wait_drain(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
